// File: rtl/jtcontra_main_ctl_if.sv
// Main-CPU bus between the 6809 core (master) and the board control logic (slave).
// The address/data/rnw lines also fan out to the video and palette chips.
interface jtcontra_main_ctl_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rnw;
    logic        cpu_vma;
    logic [7:0]  cpu_din;
    logic        cpu_cen;
    logic        cpu_irqn;
    logic        cpu_nmin;

    modport master (
        output cpu_addr, cpu_dout, cpu_rnw, cpu_vma,
        input  cpu_din, cpu_cen, cpu_irqn, cpu_nmin
    );

    modport slave (
        input  cpu_addr, cpu_dout, cpu_rnw, cpu_vma,
        output cpu_din, cpu_cen, cpu_irqn, cpu_nmin
    );
endinterface

// File: rtl/jtcontra_main_ctl.sv
// Main-CPU control for 007121 boards: CPU clock enable with ROM wait, address decode,
// ROM banking, cabinet I/O, sound latch/IRQ and video control registers.
module jtcontra_main_ctl #(
    parameter int GAME = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen12,

    jtcontra_main_ctl_if.slave cpu,

    output logic        snd_irq,
    output logic [7:0]  snd_latch,

    output logic [17:0] rom_addr,
    output logic        rom_cs,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,

    input  logic [1:0]  start_button,
    input  logic [1:0]  coin_input,
    input  logic [6:0]  joystick1,
    input  logic [6:0]  joystick2,
    input  logic        service,

    input  logic        gfx_irqn,
    input  logic        gfx_nmin,
    output logic        gfx1_cs,
    output logic        gfx2_cs,
    output logic        pal_cs,
    input  logic [7:0]  gfx1_dout,
    input  logic [7:0]  gfx2_dout,
    input  logic [7:0]  pal_dout,
    output logic [7:0]  video_bank,
    output logic        prio_latch,

    input  logic        dip_pause,
    input  logic [7:0]  dipsw_a,
    input  logic [7:0]  dipsw_b,
    input  logic [3:0]  dipsw_c
);

    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rnw;
    logic        vma;
    logic        cen;

    assign addr = cpu.cpu_addr;
    assign dout = cpu.cpu_dout;
    assign rnw  = cpu.cpu_rnw;
    assign vma  = cpu.cpu_vma;

    assign cpu.cpu_irqn = gfx_irqn;
    assign cpu.cpu_nmin = gfx_nmin;

    // ------------------------------------------------------------------
    // CPU clock enable: 12 MHz / 4, stretched while the ROM slot is busy
    // ------------------------------------------------------------------
    logic [1:0] cen_cnt_reg;
    logic       rom_wait;

    assign rom_wait = rom_cs & ~rom_ok;
    assign cen      = ~rst & cen12 & (cen_cnt_reg == 2'd3) & dip_pause & ~rom_wait;
    assign cpu.cpu_cen = cen;

    // Parking at the enable phase lets the CPU resume on the first cen12 after rom_ok.
    always_ff @(posedge clk) begin
        if (rst) begin
            cen_cnt_reg <= 2'd0;
        end else if (cen12 && !((cen_cnt_reg == 2'd3) && rom_wait)) begin
            cen_cnt_reg <= cen_cnt_reg + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic gfx1_sel;
    logic gfx2_sel;
    logic pal_sel;
    logic io_sel;
    logic ram_sel;
    logic bank_sel;
    logic fixed_sel;
    logic ram_cs;
    logic io_cs;

    assign gfx1_sel = (addr[15:3] == 13'd0) || (addr[15:13] == 3'b001);
    assign pal_sel  = (addr[15:10] == 6'b000010);
    assign io_sel   = (addr[15:5] == 11'h020);
    assign ram_sel  = ((addr[15:10] == 6'd0) && (addr[9:3] != 7'd0)) ||
                      (addr[15:11] == 5'b00010);

    if (GAME == 0) begin : g_map_dual
        assign gfx2_sel  = (addr[15:13] == 3'b010);
        assign bank_sel  = (addr[15:13] == 3'b011);
        assign fixed_sel = addr[15];
    end else begin : g_map_single
        assign gfx2_sel  = 1'b0;
        assign bank_sel  = (addr[15:13] == 3'b010);
        assign fixed_sel = addr[15] | (addr[14] & addr[13]);
    end

    assign rom_cs  = vma & (bank_sel | fixed_sel);
    assign gfx1_cs = vma & gfx1_sel;
    assign gfx2_cs = vma & gfx2_sel;
    assign pal_cs  = vma & pal_sel;
    assign ram_cs  = vma & ram_sel;
    assign io_cs   = vma & io_sel;

    // ------------------------------------------------------------------
    // ROM banking
    // ------------------------------------------------------------------
    logic [2:0] bank_reg;

    assign rom_addr = bank_sel ? {2'b01, bank_reg, addr[12:0]} : {2'b00, addr};

    // ------------------------------------------------------------------
    // Work RAM: both windows share one 4 KB block without aliasing
    // ------------------------------------------------------------------
    logic [7:0]  ram_mem [0:4095];
    logic [7:0]  ram_q_reg;
    logic [11:0] ram_idx;
    logic        ram_wr;

    assign ram_idx = {addr[12], addr[10:0]};
    assign ram_wr  = cen & ~rnw & ram_cs;

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram_mem[ram_idx] <= dout;
        end
        ram_q_reg <= ram_mem[ram_idx];
    end

    // ------------------------------------------------------------------
    // I/O write strobes, one per 4-byte register slot
    // ------------------------------------------------------------------
    logic       io_wr;
    logic [6:2] io_wr_stb;

    assign io_wr = cen & ~rnw & io_cs;

    for (genvar gi = 2; gi <= 6; gi++) begin : g_io_stb
        assign io_wr_stb[gi] = io_wr && (addr[4:0] == 5'(gi * 4));
    end

    logic [7:0] video_bank_reg;
    logic       prio_latch_reg;
    logic [7:0] snd_latch_reg;
    logic       snd_irq_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            video_bank_reg <= 8'd0;
            prio_latch_reg <= 1'b0;
            bank_reg       <= 3'd0;
            snd_latch_reg  <= 8'd0;
            snd_irq_reg    <= 1'b0;
        end else begin
            snd_irq_reg <= io_wr_stb[6];
            if (io_wr_stb[2]) video_bank_reg <= dout;
            if (io_wr_stb[3]) prio_latch_reg <= dout[0];
            if (io_wr_stb[4]) bank_reg       <= dout[2:0];
            if (io_wr_stb[5]) snd_latch_reg  <= dout;
        end
    end

    assign video_bank = video_bank_reg;
    assign prio_latch = prio_latch_reg;
    assign snd_latch  = snd_latch_reg;
    assign snd_irq    = snd_irq_reg;

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    logic [7:0] io_dout;

    always_comb begin
        io_dout = 8'hFF;
        case (addr[4:0])
            5'h00:   io_dout = {3'b111, service, start_button, coin_input};
            5'h01:   io_dout = {1'b1, joystick1};
            5'h02:   io_dout = {1'b1, joystick2};
            5'h03:   io_dout = {4'hF, dipsw_c};
            5'h04:   io_dout = dipsw_a;
            5'h05:   io_dout = dipsw_b;
            default: io_dout = 8'hFF;
        endcase
    end

    logic [7:0] din_next;

    always_comb begin
        din_next = 8'hFF;
        if (rom_cs)       din_next = rom_data;
        else if (ram_cs)  din_next = ram_q_reg;
        else if (io_cs)   din_next = io_dout;
        else if (gfx1_cs) din_next = gfx1_dout;
        else if (gfx2_cs) din_next = gfx2_dout;
        else if (pal_cs)  din_next = pal_dout;
    end

    assign cpu.cpu_din = din_next;

endmodule

// File: tb/tb_jtcontra_main_ctl.sv
// Scoreboard bench: a CPU-side driver issues bus cycles and queues predictions from an
// address-map model; a monitor compares them whenever the DUT grants a CPU enable.
module tb_jtcontra_main_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen12 = 1'b0;
    logic        snd_irq;
    logic [7:0]  snd_latch;
    logic [17:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data = 8'h00;
    logic        rom_ok = 1'b1;
    logic [1:0]  start_button = 2'b11;
    logic [1:0]  coin_input = 2'b11;
    logic [6:0]  joystick1 = 7'h7F;
    logic [6:0]  joystick2 = 7'h7F;
    logic        service = 1'b1;
    logic        gfx_irqn = 1'b1;
    logic        gfx_nmin = 1'b1;
    logic        gfx1_cs;
    logic        gfx2_cs;
    logic        pal_cs;
    logic [7:0]  gfx1_dout = 8'h00;
    logic [7:0]  gfx2_dout = 8'h00;
    logic [7:0]  pal_dout = 8'h00;
    logic [7:0]  video_bank;
    logic        prio_latch;
    logic        dip_pause = 1'b1;
    logic [7:0]  dipsw_a = 8'hFF;
    logic [7:0]  dipsw_b = 8'hFF;
    logic [3:0]  dipsw_c = 4'hF;

    jtcontra_main_ctl_if bus();

    jtcontra_main_ctl #(.GAME(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .cen12        (cen12),
        .cpu          (bus),
        .snd_irq      (snd_irq),
        .snd_latch    (snd_latch),
        .rom_addr     (rom_addr),
        .rom_cs       (rom_cs),
        .rom_data     (rom_data),
        .rom_ok       (rom_ok),
        .start_button (start_button),
        .coin_input   (coin_input),
        .joystick1    (joystick1),
        .joystick2    (joystick2),
        .service      (service),
        .gfx_irqn     (gfx_irqn),
        .gfx_nmin     (gfx_nmin),
        .gfx1_cs      (gfx1_cs),
        .gfx2_cs      (gfx2_cs),
        .pal_cs       (pal_cs),
        .gfx1_dout    (gfx1_dout),
        .gfx2_dout    (gfx2_dout),
        .pal_dout     (pal_dout),
        .video_bank   (video_bank),
        .prio_latch   (prio_latch),
        .dip_pause    (dip_pause),
        .dipsw_a      (dipsw_a),
        .dipsw_b      (dipsw_b),
        .dipsw_c      (dipsw_c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 12 MHz enable: every other clk, changed just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cen12 = ~cen12;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [15:0] addr;
        logic        rnw;
        logic        chk_din;
        logic [7:0]  din;
        logic        rcs;
        logic [17:0] raddr;
        logic        g1;
        logic        g2;
        logic        pl;
        logic [7:0]  vbank;
        logic [7:0]  slatch;
        logic        prio;
        logic        irqn;
        logic        nmin;
        logic        irq_next;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int         m_bank = 0;
    logic [7:0] m_vbank = 8'd0;
    logic [7:0] m_slatch = 8'd0;
    logic       m_prio = 1'b0;
    logic [7:0] ram_m [int];
    int         ram_list[$];

    task automatic predict(input logic [15:0] a, input logic rnw, input logic [7:0] d,
                           output exp_t e);
        int ai;
        logic [31:0] ra;
        bit rom, banked, io, ram;
        ai = {16'd0, a};
        e = '0;
        e.addr = a;
        e.rnw = rnw;
        e.chk_din = rnw;
        e.vbank = m_vbank;
        e.slatch = m_slatch;
        e.prio = m_prio;
        e.irqn = gfx_irqn;
        e.nmin = gfx_nmin;
        rom = (ai >= 'h4000);
        banked = rom && (ai < 'h6000);
        io = (ai >= 'h400) && (ai <= 'h41F);
        ram = ((ai >= 8) && (ai <= 'h3FF)) || ((ai >= 'h1000) && (ai <= 'h17FF));
        e.rcs = rom;
        ra = banked ? (32'h10000 + m_bank * 32'h2000 + (ai - 32'h4000)) : ai;
        e.raddr = ra[17:0];
        e.g1 = (ai <= 7) || ((ai >= 'h2000) && (ai <= 'h3FFF));
        e.g2 = 1'b0;
        e.pl = (ai >= 'h800) && (ai <= 'hBFF);
        e.irq_next = !rnw && (ai == 'h418);
        if (rom) e.din = rom_data;
        else if (ram) begin
            if (ram_m.exists(ai)) e.din = ram_m[ai];
            else e.chk_din = 1'b0;
        end else if (io) begin
            case (ai - 'h400)
                0: e.din = {3'b111, service, start_button, coin_input};
                1: e.din = {1'b1, joystick1};
                2: e.din = {1'b1, joystick2};
                3: e.din = {4'hF, dipsw_c};
                4: e.din = dipsw_a;
                5: e.din = dipsw_b;
                default: e.din = 8'hFF;
            endcase
        end else if (e.g1) e.din = gfx1_dout;
        else if (e.pl) e.din = pal_dout;
        else e.din = 8'hFF;
        if (!rnw) begin
            if (ram) begin
                if (!ram_m.exists(ai)) ram_list.push_back(ai);
                ram_m[ai] = d;
            end
            case (ai)
                'h408: m_vbank = d;
                'h40C: m_prio = d[0];
                'h410: m_bank = int'(d[2:0]);
                'h414: m_slatch = d;
                default: ;
            endcase
        end
    endtask

    // Monitor: one comparison set per granted CPU cycle, plus the sound IRQ pulse shape
    exp_t mon_e;
    logic irq_due = 1'b0;
    logic irq_now;
    always @(negedge clk) begin
        chk("snd_irq", snd_irq, irq_due);
        irq_now = 1'b0;
        if (bus.cpu_cen && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk_din) chk($sformatf("din@%h", mon_e.addr), bus.cpu_din, mon_e.din);
            chk($sformatf("rom_cs@%h", mon_e.addr), rom_cs, mon_e.rcs);
            if (mon_e.rcs) chk($sformatf("rom_addr@%h", mon_e.addr), rom_addr, mon_e.raddr);
            chk($sformatf("gfx1_cs@%h", mon_e.addr), gfx1_cs, mon_e.g1);
            chk($sformatf("gfx2_cs@%h", mon_e.addr), gfx2_cs, mon_e.g2);
            chk($sformatf("pal_cs@%h", mon_e.addr), pal_cs, mon_e.pl);
            chk("video_bank", video_bank, mon_e.vbank);
            chk("snd_latch", snd_latch, mon_e.slatch);
            chk("prio_latch", prio_latch, mon_e.prio);
            chk("cpu_irqn", bus.cpu_irqn, mon_e.irqn);
            chk("cpu_nmin", bus.cpu_nmin, mon_e.nmin);
            irq_now = mon_e.irq_next;
        end
        irq_due = irq_now;
    end

    // Driver: present one bus cycle and hold it until the CPU enable consumes it
    task automatic bus_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] d,
                             input int wait_clks);
        exp_t e;
        int n;
        bit seen;
        bus.cpu_addr = a;
        bus.cpu_rnw = rnw;
        bus.cpu_dout = d;
        bus.cpu_vma = 1'b1;
        rom_data = 8'($urandom);
        gfx1_dout = 8'($urandom);
        gfx2_dout = 8'($urandom);
        pal_dout = 8'($urandom);
        gfx_irqn = 1'($urandom);
        gfx_nmin = 1'($urandom);
        rom_ok = (wait_clks == 0);
        predict(a, rnw, d, e);
        exp_q.push_back(e);
        seen = 1'b0;
        if (wait_clks > 0) begin
            n = 0;
            repeat (wait_clks) begin
                @(negedge clk);
                if (bus.cpu_cen) n++;
            end
            chk("wait_no_cen", n, 0);
            chk("wait_rom_cs", rom_cs, 1);
            chk("wait_rom_addr", rom_addr, e.raddr);
            @(posedge clk);
            #1;
            rom_ok = 1'b1;
            for (int i = 0; i < 4 && !seen; i++) begin
                @(negedge clk);
                seen = bus.cpu_cen;
            end
            chk("wait_release_cen", seen, 1);
        end else begin
            for (int i = 0; i < 64 && !seen; i++) begin
                @(negedge clk);
                seen = bus.cpu_cen;
            end
            chk("cen_timeout", seen, 1);
        end
        if (!seen && exp_q.size() > 0) void'(exp_q.pop_back());
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        start_button = 2'($urandom);
        coin_input = 2'($urandom);
        joystick1 = 7'($urandom);
        joystick2 = 7'($urandom);
        service = 1'($urandom);
        dipsw_a = 8'($urandom);
        dipsw_b = 8'($urandom);
        dipsw_c = 4'($urandom);
    endtask

    function automatic logic [15:0] ram_addr_rand();
        if ($urandom_range(0, 1) == 0) return 16'($urandom_range('h008, 'h3FF));
        return 16'($urandom_range('h1000, 'h17FF));
    endfunction

    initial begin
        #1000000;
        failures++;
        $display("FAIL global_timeout: got 0x0 expected 0x1 (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t[4];
        int k;
        int n;
        int r;
        logic [15:0] a;
        logic [7:0] offs [6];
        offs = '{8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
        t = '{0, 0, 0, 0};
        bus.cpu_addr = 16'h0000;
        bus.cpu_dout = 8'h00;
        bus.cpu_rnw = 1'b1;
        bus.cpu_vma = 1'b0;

        // Reset held for 4 clk
        repeat (4) begin
            @(negedge clk);
            chk("rst_cpu_cen", bus.cpu_cen, 0);
            chk("rst_snd_latch", snd_latch, 0);
            chk("rst_video_bank", video_bank, 0);
            chk("rst_prio_latch", prio_latch, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Free-running CPU enable cadence
        k = 0;
        for (int i = 0; i < 100 && k < 4; i++) begin
            @(negedge clk);
            if (bus.cpu_cen) begin
                t[k] = cyc;
                k++;
            end
        end
        chk("cen_pulses", k, 4);
        for (int i = 1; i < 4; i++) chk("cen_period", t[i] - t[i-1], 8);
        @(posedge clk);
        #1;

        // Directed cases
        bus_cycle(16'h8000, 1'b1, 8'h00, 20);
        bus_cycle(16'h0410, 1'b0, 8'h05, 0);
        bus_cycle(16'h4123, 1'b1, 8'h00, 0);
        bus_cycle(16'h0410, 1'b0, 8'h07, 0);
        bus_cycle(16'h5FFF, 1'b1, 8'h00, 0);
        joystick1 = 7'h5E;
        bus_cycle(16'h0401, 1'b1, 8'h00, 0);
        dipsw_c = 4'h3;
        bus_cycle(16'h0403, 1'b1, 8'h00, 0);
        bus_cycle(16'h0420, 1'b1, 8'h00, 0);
        bus_cycle(16'h0414, 1'b0, 8'h22, 0);
        bus_cycle(16'h0418, 1'b0, 8'($urandom), 0);
        bus_cycle(16'h0800, 1'b1, 8'h00, 0);
        bus_cycle(16'h2000, 1'b1, 8'h00, 0);
        bus_cycle(16'h0408, 1'b0, 8'hA5, 0);
        bus_cycle(16'h040C, 1'b0, 8'h01, 0);
        bus_cycle(16'h0010, 1'b0, 8'h3C, 0);
        bus_cycle(16'h1010, 1'b0, 8'hC3, 0);
        bus_cycle(16'h0010, 1'b1, 8'h00, 0);
        bus_cycle(16'h1010, 1'b1, 8'h00, 0);

        // Pause switch stops the CPU
        bus.cpu_vma = 1'b0;
        dip_pause = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.cpu_cen) n++;
        end
        chk("pause_no_cen", n, 0);
        @(posedge clk);
        #1;
        dip_pause = 1'b1;

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            rand_inputs();
            r = $urandom_range(0, 9);
            case (r)
                0: bus_cycle(16'($urandom_range('h6000, 'hFFFF)), 1'b1, 8'h00, 0);
                1: bus_cycle(16'($urandom_range('h4000, 'h5FFF)), 1'b1, 8'h00, 0);
                2: begin
                    a = 16'h0400 + {8'h00, offs[$urandom_range(0, 5)]};
                    bus_cycle(a, 1'b0, 8'($urandom), 0);
                end
                3: bus_cycle(16'($urandom_range('h400, 'h41F)), 1'b1, 8'h00, 0);
                4: bus_cycle(ram_addr_rand(), 1'b0, 8'($urandom), 0);
                5: begin
                    if (ram_list.size() > 0)
                        a = 16'(ram_list[$urandom_range(0, ram_list.size() - 1)]);
                    else
                        a = ram_addr_rand();
                    bus_cycle(a, 1'b1, 8'h00, 0);
                end
                6: bus_cycle(16'($urandom_range('h800, 'hBFF)), 1'b1, 8'h00, 0);
                7: begin
                    if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 7));
                    else a = 16'($urandom_range('h2000, 'h3FFF));
                    bus_cycle(a, 1'b1, 8'h00, 0);
                end
                8: begin
                    if ($urandom_range(0, 1) == 0) a = 16'($urandom_range('hC00, 'hFFF));
                    else a = 16'($urandom_range('h1800, 'h1FFF));
                    bus_cycle(a, 1'b1, 8'h00, 0);
                end
                default: bus_cycle(16'($urandom_range('h4000, 'hFFFF)), 1'b1, 8'h00,
                                   $urandom_range(8, 16));
            endcase
        end

        bus.cpu_vma = 1'b0;
        repeat (10) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
